bpu_btb: RTL

- Parametrised branch prediction unit with a tagged, direct-mapped branch target buffer (BTB) and per-entry saturating direction counters.
- Fetch side: combinational lookup supplies a next-PC prediction in the same cycle.
- Execute side: a resolved-branch update port trains the BTB and counters one clock later.
- Sits between pc_reg/if and the ex-stage branch resolution; replaces the untagged 16-entry target list in the control block.

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_btb_if.sv | 28 ++
 rtl/bpu_ras.sv | 45 ++++
 rtl/bpu_btb.sv | 107 ++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: branch kinds, BTB entry layout
// and counter helpers.
package bpu_pkg;

  localparam int unsigned BPU_XLEN  = 32;
  localparam int unsigned BPU_TAG_W = 8;
  localparam int unsigned BPU_CNT_W = 2;

  typedef enum logic [1:0] {
    BK_COND = 2'd0,
    BK_JAL  = 2'd1,
    BK_CALL = 2'd2,
    BK_RET  = 2'd3
  } br_kind_e;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_XLEN-1:0]  target;
    br_kind_e             kind;
    logic [BPU_CNT_W-1:0] cnt;
  } btb_entry_t;

  // Counter value written on allocation: weakly taken.
  localparam logic [BPU_CNT_W-1:0] BPU_CNT_RST = BPU_CNT_W'(1 << (BPU_CNT_W - 1));

  function automatic int unsigned cnt_weak(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/bpu_btb_if.sv
// Fetch-side lookup and execute-side update signals of the branch predictor.
interface bpu_btb_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            if_valid_i;
  logic [XLEN-1:0] if_pc_i;
  logic            pred_hit_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [1:0]      upd_kind_i;
  logic            upd_mispredict_i;

  modport master (
    output if_valid_i, if_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_kind_i, upd_mispredict_i,
    input  pred_hit_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  if_valid_i, if_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_kind_i, upd_mispredict_i,
    output pred_hit_o, pred_taken_o, pred_target_o
  );
endinterface

// File: rtl/bpu_ras.sv
// Circular return address stack; when full, a push overwrites the oldest entry.
module bpu_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [XLEN-1:0] top,
  output logic            nz
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  stk [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  // ptr_q points at the next free slot; the top of stack sits one below it.
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  assign top     = stk[ptr_dec];
  assign nz      = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (push) begin
      stk[ptr_q] <= push_data;
      ptr_q      <= ptr_inc;
      if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (pop) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/bpu_btb.sv
// Tagged direct-mapped BTB with saturating direction counters.
// Optional return address stack enabled by defining BPU_RAS_EN.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN      = BPU_XLEN,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = BPU_TAG_W,
  parameter int unsigned CNT_W     = BPU_CNT_W,
  parameter int unsigned RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  bpu_btb_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(cnt_weak(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             v_q      [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  br_kind_e         kind_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  br_kind_e         f_kind, u_kind;
  logic [XLEN-1:0]  f_pc4, f_target;
  logic             f_taken;

  assign f_idx  = bus.if_pc_i[TAG_LO-1:2];
  assign f_tag  = bus.if_pc_i[TAG_LO+TAG_W-1:TAG_LO];
  assign u_idx  = bus.upd_pc_i[TAG_LO-1:2];
  assign u_tag  = bus.upd_pc_i[TAG_LO+TAG_W-1:TAG_LO];
  assign u_kind = br_kind_e'(bus.upd_kind_i);
  assign f_pc4  = bus.if_pc_i + XLEN'(4);

  assign f_hit   = bus.if_valid_i && v_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_kind  = kind_q[f_idx];
  assign f_taken = f_hit && ((f_kind != BK_COND) || cnt_q[f_idx][CNT_W-1]);
  assign u_hit   = v_q[u_idx] && (tag_q[u_idx] == u_tag);

  logic unused_pc;
  assign unused_pc = ^{bus.if_pc_i, bus.upd_pc_i};

`ifdef BPU_RAS_EN
  logic            ras_push, ras_pop, ras_nz;
  logic [XLEN-1:0] ras_top;

  assign ras_push = f_hit && (f_kind == BK_CALL);
  assign ras_pop  = f_hit && (f_kind == BK_RET) && ras_nz;
  assign f_target = ras_pop ? ras_top : target_q[f_idx];

  bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .push_data (f_pc4),
    .pop       (ras_pop),
    .flush     (bus.upd_mispredict_i),
    .top       (ras_top),
    .nz        (ras_nz)
  );
`else
  logic        unused_mispredict;
  logic [31:0] unused_ras_depth;
  assign f_target          = target_q[f_idx];
  assign unused_mispredict = bus.upd_mispredict_i;
  assign unused_ras_depth  = RAS_DEPTH;
`endif

  assign bus.pred_hit_o    = f_hit;
  assign bus.pred_taken_o  = f_taken;
  assign bus.pred_target_o = f_taken ? f_target : f_pc4;

  // Lookup reads the arrays directly, so a same-cycle update is not bypassed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        v_q[i]   <= 1'b0;
        cnt_q[i] <= '0;
      end
    end else if (bus.upd_valid_i) begin
      if (u_hit) begin
        if (bus.upd_taken_i) begin
          if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + 1'b1;
          target_q[u_idx] <= bus.upd_target_i;
          kind_q[u_idx]   <= u_kind;
        end else if (cnt_q[u_idx] != '0) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - 1'b1;
        end
      end else if (bus.upd_taken_i) begin
        v_q[u_idx]      <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bus.upd_target_i;
        kind_q[u_idx]   <= u_kind;
        cnt_q[u_idx]    <= CNT_WEAK;
      end
    end
  end
endmodule
